// File: rtl/key_reg_arbiter_if.sv
// key_reg_arbiter_if
//   Request/grant/write bus between the crypto engines and the key register
//   arbiter.
//   master : requester side. Drives req, op and wdata; sees the grant,
//            completion and key-register status.
//   slave  : arbiter side.
//   Signals
//     req     [N_REQ]        per-requester access request
//     op      [2*N_REQ]      per-requester command, op[2i+1:2i]
//                            (00 load, 01 clear, 10 set, 11 reserved)
//     wdata   [WIDTH*N_REQ]  per-requester load data, slice i = wdata[WIDTH*i +: WIDTH]
//     gnt     [N_REQ]        one-hot grant
//     ack     [N_REQ]        one-hot, one-cycle completion pulse
//     err                    reserved-op pulse, coincident with ack
//     q       [WIDTH]        shared key register
//     q_valid                q holds a loaded or set value
//     busy                   arbiter is not idle
interface key_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic                   err;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic                   busy;

  modport master (
    output req, op, wdata,
    input  gnt, ack, err, q, q_valid, busy
  );

  modport slave (
    input  req, op, wdata,
    output gnt, ack, err, q, q_valid, busy
  );
endinterface

// File: rtl/key_reg_arbiter.sv
// key_reg_arbiter
//   Round-robin arbiter and write sequencer for one shared WIDTH-bit key
//   register. One requester is granted at a time; its command (load, clear,
//   set) is applied to q one cycle after the grant, with a one-cycle ack.
//   Ports
//     clk    rising-edge clock
//     clear  synchronous reset, active-high; aborts any transaction in flight
//     bus    key_reg_arbiter_if.slave (req/op/wdata in; gnt/ack/err/q/q_valid/busy out)
module key_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clear,
  key_reg_arbiter_if.slave   bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    win_q, win_d;
  logic [IW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qv_q, qv_d;

  // Round-robin pick: first set req at or after last+1, wrapping.
  logic [IW-1:0] pick;
  logic          found;
  int            idx;
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    err_d   = err_q;
    q_d     = q_q;
    qv_d    = qv_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d        = pick;
          gnt_d        = '0;
          gnt_d[pick]  = 1'b1;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        // A requester that dropped req before this edge has withdrawn:
        // nothing is written and no ack is produced.
        if (bus.req[win_q]) begin
          case (bus.op[2*win_q +: 2])
            2'b00: begin q_d = bus.wdata[WIDTH*win_q +: WIDTH]; qv_d = 1'b1; end
            2'b01: begin q_d = '0;                              qv_d = 1'b0; end
            2'b10: begin q_d = '1;                              qv_d = 1'b1; end
            default: err_d = 1'b1;
          endcase
          ack_d        = '0;
          ack_d[win_q] = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        gnt_d   = '0;
        ack_d   = '0;
        err_d   = 1'b0;
        // Pointer advances even after a withdrawal so the withdrawn
        // requester does not keep priority.
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      q_q     <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.q       = q_q;
  assign bus.q_valid = qv_q;
  assign bus.busy    = (state_q != IDLE);
endmodule
